// File: rtl/tts_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tts_pkg
// Description : Shared types, constants and helpers for truth_table_sweeper.
// Revision    : 1.0 - initial release
// ============================================================================
package tts_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [15:0] c_misr_poly = 16'h1021;

    function automatic int vec_count(input int n);
        return 1 << n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/truth_table_sweeper_if.sv
`default_nettype none
// ============================================================================
// Module      : truth_table_sweeper_if
// Description : Control/result bundle between a sweep controller and the sweeper.
// Revision    : 1.0 - initial release
// ============================================================================
interface truth_table_sweeper_if
    import tts_pkg::*;
#(
    parameter int N_IN  = 4,
    parameter int N_OUT = 1
);
    localparam int c_v = vec_count(N_IN);

    logic                   start;
    logic                   abort;
    logic [N_OUT*c_v-1:0]   exp_table;
    logic                   busy;
    logic                   done;
    logic                   pass;
    logic [N_IN:0]          fail_cnt;
    logic [N_IN-1:0]        first_fail;
    logic [N_OUT*c_v-1:0]   table_out;

    modport master (
        output start, abort, exp_table,
        input  busy, done, pass, fail_cnt, first_fail, table_out
    );

    modport slave (
        input  start, abort, exp_table,
        output busy, done, pass, fail_cnt, first_fail, table_out
    );

endinterface
`default_nettype wire

// File: rtl/tts_checker.sv
`default_nettype none
// ============================================================================
// Module      : tts_checker
// Description : Per-sample response compare, mismatch tracking and optional
//               response MISR (enabled by TTS_MISR_EN).
// Revision    : 1.0 - initial release
// ============================================================================
module tts_checker
    import tts_pkg::*;
#(
    parameter int N_IN  = 4,
    parameter int N_OUT = 1
) (
    input  wire logic               clk,
    input  wire logic               rst_n,
    input  wire logic               i_sample,
    input  wire logic               i_clear,
    input  wire logic [N_IN-1:0]    i_idx,
    input  wire logic [N_OUT-1:0]   i_resp,
    input  wire logic [N_OUT-1:0]   i_exp,
    output logic [N_IN:0]           o_fail_cnt,
    output logic [N_IN-1:0]         o_first_fail
`ifdef TTS_MISR_EN
   ,output logic [15:0]             o_signature
`endif
);

    logic [N_IN:0]   r_fail_cnt;
    logic [N_IN-1:0] r_first_fail;
    logic            w_mismatch;

    assign w_mismatch = (i_resp != i_exp);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fail_cnt   <= '0;
            r_first_fail <= '0;
        end else if (i_clear) begin
            r_fail_cnt   <= '0;
            r_first_fail <= '0;
        end else if (i_sample && w_mismatch) begin
            r_fail_cnt <= r_fail_cnt + 1'b1;
            if (r_fail_cnt == '0) begin
                r_first_fail <= i_idx;
            end
        end
    end

    assign o_fail_cnt   = r_fail_cnt;
    assign o_first_fail = r_first_fail;

`ifdef TTS_MISR_EN
    logic [15:0] r_sig;

    // Shift-left CRC-style MISR folding each sampled response into bit 0 upward.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sig <= '0;
        end else if (i_clear) begin
            r_sig <= '0;
        end else if (i_sample) begin
            r_sig <= {r_sig[14:0], 1'b0}
                   ^ (r_sig[15] ? c_misr_poly : 16'h0000)
                   ^ 16'(i_resp);
        end
    end

    assign o_signature = r_sig;
`endif

endmodule
`default_nettype wire

// File: rtl/truth_table_sweeper.sv
`default_nettype none
// ============================================================================
// Module      : truth_table_sweeper
// Description : Exhaustive input sweeper that captures and checks a DUT truth
//               table. Optional MISR signature port under TTS_MISR_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module truth_table_sweeper
    import tts_pkg::*;
#(
    parameter int N_IN  = 4,
    parameter int N_OUT = 1,
    parameter int DWELL = 1
) (
    input  wire logic               clk,
    input  wire logic               rst_n,
    truth_table_sweeper_if.slave    bus,
    output logic [N_IN-1:0]         stim,
    input  wire logic [N_OUT-1:0]   resp
`ifdef TTS_MISR_EN
   ,output logic [15:0]             signature
`endif
);

    localparam int                c_v          = vec_count(N_IN);
    localparam int                c_dw         = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [c_dw-1:0]   c_dwell_last = c_dw'(DWELL - 1);
    localparam logic [N_IN-1:0]   c_idx_last   = N_IN'(c_v - 1);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [N_IN-1:0]        r_idx;
    logic [c_dw-1:0]        r_dwell;
    logic [N_OUT*c_v-1:0]   r_table;
    logic                   r_pass;
    logic                   w_go;
    logic                   w_last_dwell;
    logic                   w_sample;
    logic                   w_busy;
    logic                   w_done;
    logic [N_IN:0]          w_fail_cnt;
    logic [N_IN-1:0]        w_first_fail;
    logic [N_OUT-1:0]       w_exp_slice;

    assign w_go         = (r_state == ST_IDLE) && bus.start && !bus.abort;
    assign w_last_dwell = (r_dwell == c_dwell_last);
    // Abort on the sampling edge discards that sample.
    assign w_sample     = (r_state == ST_SWEEP) && w_last_dwell && !bus.abort;
    assign w_exp_slice  = bus.exp_table[32'(r_idx)*N_OUT +: N_OUT];

    always_comb begin
        w_state_nxt = r_state;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_go) begin
                    w_state_nxt = ST_SWEEP;
                end
            end
            ST_SWEEP: begin
                w_busy = 1'b1;
                if (bus.abort) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_sample && (r_idx == c_idx_last)) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_done      = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx   <= '0;
            r_dwell <= '0;
            r_table <= '0;
            r_pass  <= 1'b0;
        end else if (w_go) begin
            r_idx   <= '0;
            r_dwell <= '0;
            r_table <= '0;
            r_pass  <= 1'b0;
        end else if (r_state == ST_SWEEP) begin
            if (bus.abort) begin
                r_idx   <= '0;
                r_dwell <= '0;
                r_pass  <= 1'b0;
            end else if (w_last_dwell) begin
                r_table[32'(r_idx)*N_OUT +: N_OUT] <= resp;
                r_dwell <= '0;
                // idx parks at the last vector so stim holds it after DONE.
                if (r_idx != c_idx_last) begin
                    r_idx <= r_idx + 1'b1;
                end
            end else begin
                r_dwell <= r_dwell + 1'b1;
            end
        end else if (r_state == ST_DONE) begin
            r_pass <= (w_fail_cnt == '0);
        end
    end

    tts_checker #(
        .N_IN  (N_IN),
        .N_OUT (N_OUT)
    ) u_checker (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_sample     (w_sample),
        .i_clear      (w_go),
        .i_idx        (r_idx),
        .i_resp       (resp),
        .i_exp        (w_exp_slice),
        .o_fail_cnt   (w_fail_cnt),
        .o_first_fail (w_first_fail)
`ifdef TTS_MISR_EN
       ,.o_signature  (signature)
`endif
    );

    assign stim           = r_idx;
    assign bus.busy       = w_busy;
    assign bus.done       = w_done;
    assign bus.pass       = w_done ? (w_fail_cnt == '0) : r_pass;
    assign bus.fail_cnt   = w_fail_cnt;
    assign bus.first_fail = w_first_fail;
    assign bus.table_out  = r_table;

endmodule
`default_nettype wire
